sffrb_capture: RTL and testbench

//  Readback side of the sffsrce state path: snapshots the q outputs of a bank of

---
 rtl/sffrb_capture_pkg.sv | 26 ++
 rtl/sffrb_capture_if.sv | 27 ++
 rtl/sffrb_capture_shreg.sv | 40 ++++
 rtl/sffrb_capture.sv | 90 +++++++++
 tb/tb_sffrb_capture.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sffrb_capture_pkg.sv
// Shared types and helpers for the sffrb_capture readback path:
// FSM state encoding and counter-width arithmetic.
package sffrb_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Bit counter width; a one-bit snapshot still keeps a one-bit counter.
  function automatic int cnt_width(input int width);
    return clog2((width < 2) ? 2 : width);
  endfunction

endpackage

// File: rtl/sffrb_capture_if.sv
// Control, snapshot input and serial readback stream of sffrb_capture.
// The master side is the capture block; the slave side is the debug port.
interface sffrb_capture_if #(
  parameter int WIDTH = 32
);
  logic             ce;
  logic             cap;
  logic             clr_ovr;
  logic [WIDTH-1:0] state_in;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    input  ce, cap, clr_ovr, state_in, sout_ready,
    output sout, sout_valid, sout_last, busy, done, overrun
  );

  modport slave (
    output ce, cap, clr_ovr, state_in, sout_ready,
    input  sout, sout_valid, sout_last, busy, done, overrun
  );
endinterface

// File: rtl/sffrb_capture_shreg.sv
// Shadow register for sffrb_capture: parallel load of the flop-bank snapshot,
// then one-bit shifts toward the output end, MSB or LSB first.
module sffrb_shreg #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_bit_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  // NOTE: next-state gets a hold default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shadow_d = shadow_q;
    if (load_i) begin
      shadow_d = data_i;
    end else if (shift_i) begin
      shadow_d = MSB_FIRST ? (shadow_q << 1) : (shadow_q >> 1);
    end
  end

  // NOTE: the shadow is a small flop bank, so it is cleared on reset; an aborted stream never leaves stale bits on sout.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign out_bit_o = MSB_FIRST ? shadow_q[WIDTH-1] : shadow_q[0];

endmodule

// File: rtl/sffrb_capture.sv
// Snapshot-and-stream readback of a WIDTH-bit flop bank: capture on cap,
// then one bit per valid/ready handshake, with done pulse and sticky overrun.
module sffrb_capture
  import sffrb_capture_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  sffrb_capture_if.master bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             load;
  logic             take;
  logic             is_last;
  logic             shreg_bit;

  assign is_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    take    = 1'b0;
    if (bus.ce) begin
      take = (state_q == ST_SHIFT) && bus.sout_ready;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cap) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (take) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_last) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // Clear first so a same-edge overrun set takes priority.
      if (bus.clr_ovr) ovr_d = 1'b0;
      if (bus.cap && (state_q != ST_IDLE)) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  sffrb_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (load),
    .shift_i   (take),
    .data_i    (bus.state_in),
    .out_bit_o (shreg_bit)
  );

  // Every output decodes registered state only; sout_ready and cap never reach them.
  assign bus.sout_valid = (state_q == ST_SHIFT);
  assign bus.sout       = bus.sout_valid & shreg_bit;
  assign bus.sout_last  = bus.sout_valid & is_last;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sffrb_capture.sv
// Scoreboard bench for sffrb_capture: three configurations (8 MSB-first,
// 8 LSB-first, 1-bit) share one directed-then-random stimulus stream.
`timescale 1ns/1ps
module tb_sffrb_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce;
  logic        cap;
  logic        clr_ovr;
  logic        sout_ready;
  logic [31:0] state_in;
  bit          drained = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 2) ? 1 : 8;
    localparam bit M = (g != 1);

    sffrb_capture_if #(.WIDTH(W)) bus ();

    assign bus.ce         = ce;
    assign bus.cap        = cap;
    assign bus.clr_ovr    = clr_ovr;
    assign bus.sout_ready = sout_ready;
    assign bus.state_in   = state_in[W-1:0];

    sffrb_capture #(.WIDTH(W), .MSB_FIRST(M)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Reference: a snapshot becomes a list of W expected {bit,last} items in
    // stream order; remaining/in_done/ovr describe what the port must show.
    logic [1:0] exp_q[$];
    int         remaining = 0;
    bit         in_done   = 1'b0;
    bit         ovr       = 1'b0;

    initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        remaining = 0;
        in_done   = 1'b0;
        ovr       = 1'b0;
      end else if (ce) begin
        bit busy_m;
        bit set_ovr;
        logic [W-1:0] snap;
        busy_m  = (remaining > 0) || in_done;
        set_ovr = cap && busy_m;
        snap    = state_in[W-1:0];
        if (in_done) begin
          in_done = 1'b0;
        end else if (remaining > 0) begin
          if (sout_ready) begin
            remaining--;
            if (remaining == 0) in_done = 1'b1;
          end
        end else if (cap) begin
          for (int i = 0; i < W; i++) begin
            int idx;
            idx = M ? (W - 1 - i) : i;
            exp_q.push_back({snap[idx], (i == W - 1) ? 1'b1 : 1'b0});
          end
          remaining = W;
        end
        if (set_ovr) ovr = 1'b1;
        else if (clr_ovr) ovr = 1'b0;
      end
    end

    // Monitor: compares status every cycle, pops one item per handshake.
    initial forever begin
      @(negedge clk);
      check($sformatf("g%0d valid", g), bus.sout_valid, remaining > 0);
      check($sformatf("g%0d busy", g), bus.busy, (remaining > 0) || in_done);
      check($sformatf("g%0d done", g), bus.done, in_done);
      check($sformatf("g%0d overrun", g), bus.overrun, ovr);
      if (bus.sout_valid && sout_ready && ce) begin
        check($sformatf("g%0d item_available", g), exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [1:0] item;
          item = exp_q.pop_front();
          check($sformatf("g%0d sout", g), bus.sout, item[1]);
          check($sformatf("g%0d sout_last", g), bus.sout_last, item[0]);
        end
      end
    end

    // Reset must clear every output without waiting for a clock.
    initial forever begin
      @(negedge rst);
      #1;
      check($sformatf("g%0d rst sout", g), bus.sout, 0);
      check($sformatf("g%0d rst valid", g), bus.sout_valid, 0);
      check($sformatf("g%0d rst last", g), bus.sout_last, 0);
      check($sformatf("g%0d rst busy", g), bus.busy, 0);
      check($sformatf("g%0d rst done", g), bus.done, 0);
      check($sformatf("g%0d rst overrun", g), bus.overrun, 0);
    end

    initial begin
      wait (drained);
      check($sformatf("g%0d leftover_items", g), exp_q.size(), 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic capture(input logic [31:0] value);
    state_in = value;
    cap      = 1'b1;
    cyc(1);
    cap      = 1'b0;
  endtask

  initial begin
    ce = 1'b1; cap = 1'b0; clr_ovr = 1'b0; sout_ready = 1'b1; state_in = '0;
    cyc(2);
    rst = 1'b1;
    cyc(1);

    // A5 with ready held high; input changes after capture must not matter.
    capture(32'hA5);
    state_in = 32'h5A;
    cyc(12);

    // Ready toggling: every bit held until accepted.
    capture(32'hA5);
    state_in = $urandom;
    for (int i = 0; i < 24; i++) begin
      sout_ready = ~sout_ready;
      cyc(1);
    end
    sout_ready = 1'b1;
    cyc(4);

    // Capture attempt mid-stream: data ignored, overrun sticks until cleared.
    capture(32'hA5);
    cyc(3);
    capture(32'hFF);
    cyc(12);
    clr_ovr = 1'b1;
    cyc(1);
    clr_ovr = 1'b0;
    cyc(2);

    // Clock enable low for five cycles mid-stream.
    capture(32'hA5);
    cyc(3);
    ce = 1'b0;
    cyc(5);
    ce = 1'b1;
    cyc(12);

    // Asynchronous reset mid-stream, then a fresh snapshot.
    capture(32'hA5);
    state_in = 32'h3C;
    cyc(3);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    capture(32'h3C);
    cyc(12);

    // Overrun set and clear on the same edge: set wins.
    capture(32'h96);
    cap = 1'b1; clr_ovr = 1'b1;
    cyc(1);
    cap = 1'b0; clr_ovr = 1'b0;
    cyc(12);

    for (int i = 0; i < 2000; i++) begin
      ce         = ($urandom_range(0, 9) != 0);
      cap        = ($urandom_range(0, 7) == 0);
      sout_ready = $urandom_range(0, 1);
      clr_ovr    = ($urandom_range(0, 15) == 0);
      state_in   = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      cyc(1);
    end

    ce = 1'b1; cap = 1'b0; clr_ovr = 1'b0; sout_ready = 1'b1;
    cyc(20);
    drained = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
